rc4_ksa_engine: RTL

Parametrised RC4 key-scheduling engine. It owns the S memory port for the whole schedule: it fills S[i] = i, then runs the key-dependent shuffle. It drives a single-port synchronous RAM and reports completion with a start/busy/done handshake. It sits between the switch/key front end and the S memory, and replaces the hand-written init/shuffle mux in the top level.

---
 rtl/rc4_ksa_engine_if.sv | 31 +++
 rtl/rc4_ksa_engine.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa_engine_if.sv
// +----------------------------------------------------------------------+
// | rc4_ksa_engine_if : start/busy/done handshake plus S memory port      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface rc4_ksa_engine_if #(
  parameter int KEY_LENGTH = 3,
  parameter int ADDR_WIDTH = 8
) ();
  logic                    start;
  logic [KEY_LENGTH*8-1:0] secret_key;
  logic                    busy;
  logic                    done;
  logic [ADDR_WIDTH-1:0]   mem_q;
  logic [ADDR_WIDTH-1:0]   mem_address;
  logic [ADDR_WIDTH-1:0]   mem_data;
  logic                    mem_wren;

  modport slave (
    input  start, secret_key, mem_q,
    output busy, done, mem_address, mem_data, mem_wren
  );

  modport master (
    output start, secret_key, mem_q,
    input  busy, done, mem_address, mem_data, mem_wren
  );
endinterface

`default_nettype wire

// File: rtl/rc4_ksa_engine.sv
// +----------------------------------------------------------------------+
// | rc4_ksa_engine : RC4 key schedule, fills S[i]=i then key-shuffles S   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rc4_ksa_engine #(
  parameter int KEY_LENGTH = 3,
  parameter int ADDR_WIDTH = 8
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  rc4_ksa_engine_if.slave bus
);

  localparam int KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  localparam int KSLOTS = 1 << KIDX_W;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_LENGTH - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_INIT   = 4'd1;
  localparam logic [3:0] S_RD_I   = 4'd2;
  localparam logic [3:0] S_WAIT_I = 4'd3;
  localparam logic [3:0] S_RD_J   = 4'd4;
  localparam logic [3:0] S_WAIT_J = 4'd5;
  localparam logic [3:0] S_WR_I   = 4'd6;
  localparam logic [3:0] S_WR_J   = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  logic [3:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   i_q, i_d;
  logic [ADDR_WIDTH-1:0]   j_q, j_d;
  logic [ADDR_WIDTH-1:0]   si_q, si_d;
  logic [KIDX_W-1:0]       kidx_q, kidx_d;
  logic [KEY_LENGTH*8-1:0] key_q, key_d;

  logic [7:0]              key_bytes [KSLOTS];
  logic [ADDR_WIDTH-1:0]   key_ext;
  logic [ADDR_WIDTH-1:0]   jn;
  logic                    last_i;

  // Byte 0 is the most significant key byte; unused slots read as zero.
  for (genvar k = 0; k < KSLOTS; k++) begin : g_key_bytes
    if (k < KEY_LENGTH) begin : g_used
      assign key_bytes[k] = key_q[(KEY_LENGTH-k)*8-1 -: 8];
    end else begin : g_pad
      assign key_bytes[k] = 8'd0;
    end
  end

  if (ADDR_WIDTH > 8) begin : g_key_zext
    assign key_ext = {{(ADDR_WIDTH-8){1'b0}}, key_bytes[kidx_q]};
  end else begin : g_key_trunc
    assign key_ext = key_bytes[kidx_q][ADDR_WIDTH-1:0];
  end

  assign jn     = j_q + bus.mem_q + key_ext;
  assign last_i = &i_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_IDLE;
      S_INIT:   state_d = last_i ? S_RD_I : S_INIT;
      S_RD_I:   state_d = S_WAIT_I;
      S_WAIT_I: state_d = S_RD_J;
      S_RD_J:   state_d = S_WAIT_J;
      S_WAIT_J: state_d = S_WR_I;
      S_WR_I:   state_d = S_WR_J;
      S_WR_J:   state_d = last_i ? S_DONE : S_RD_I;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
    if (bus.start) begin
      state_d = S_INIT;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      i_q    <= '0;
      j_q    <= '0;
      si_q   <= '0;
      kidx_q <= '0;
      key_q  <= '0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      si_q   <= si_d;
      kidx_q <= kidx_d;
      key_q  <= key_d;
    end
  end

  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    si_d   = si_q;
    kidx_d = kidx_q;
    key_d  = key_q;
    case (state_q)
      S_INIT: i_d = i_q + ADDR_WIDTH'(1);
      S_RD_J: begin
        j_d  = jn;
        si_d = bus.mem_q;
      end
      S_WR_J: begin
        if (!last_i) begin
          i_d    = i_q + ADDR_WIDTH'(1);
          kidx_d = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
        end
      end
      default: ;
    endcase
    // A start in any state discards all schedule progress.
    if (bus.start) begin
      key_d  = bus.secret_key;
      i_d    = '0;
      j_d    = '0;
      kidx_d = '0;
    end
  end

  always_comb begin
    bus.mem_address = '0;
    bus.mem_data    = '0;
    bus.mem_wren    = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    case (state_q)
      S_INIT: begin
        bus.mem_address = i_q;
        bus.mem_data    = i_q;
        bus.mem_wren    = 1'b1;
        bus.busy        = 1'b1;
      end
      S_RD_I, S_WAIT_I: begin
        bus.mem_address = i_q;
        bus.busy        = 1'b1;
      end
      S_RD_J: begin
        bus.mem_address = jn;
        bus.busy        = 1'b1;
      end
      S_WAIT_J: begin
        bus.mem_address = j_q;
        bus.busy        = 1'b1;
      end
      S_WR_I: begin
        bus.mem_address = i_q;
        bus.mem_data    = bus.mem_q;
        bus.mem_wren    = 1'b1;
        bus.busy        = 1'b1;
      end
      S_WR_J: begin
        bus.mem_address = j_q;
        bus.mem_data    = si_q;
        bus.mem_wren    = 1'b1;
        bus.busy        = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire
